// File: rtl/uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_buffer
// Brief    : First-word-fall-through byte FIFO between the UART receiver and
//            transmitter. Swaps the case of ASCII letters as bytes are
//            written, then replays them to the transmitter in order.
// Options  : UART_ECHO_LINE_MODE_EN - hold output until a CR (0x0D) is
//            buffered or the FIFO is full.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_wdata;

    // Occupancy alone decides full/empty, so pointer equality is never ambiguous.
    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);
    assign rx_ready = !w_full;
    assign tx_data  = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;
    assign w_push   = rx_valid && rx_ready;
    assign w_pop    = tx_valid && tx_ready;

    // Case swap only makes sense for byte-wide data; other widths pass through.
    generate
        if (WIDTH == 8) begin : g_case_swap
            assign w_wdata = (rx_data >= 8'h41 && rx_data <= 8'h5A) ? rx_data + 8'h20 :
                             (rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 :
                             rx_data;
        end else begin : g_pass_through
            assign w_wdata = rx_data;
        end
    endgenerate

`ifdef UART_ECHO_LINE_MODE_EN
    localparam logic [WIDTH-1:0] c_CR = WIDTH'(8'h0D);

    logic [c_CW-1:0] r_cr_count;
    logic            w_push_cr;
    logic            w_pop_cr;

    assign w_push_cr = w_push && (w_wdata == c_CR);
    assign w_pop_cr  = w_pop && (tx_data == c_CR);

    // A line is released once a CR is buffered; a full buffer releases regardless.
    assign tx_valid = !w_empty && ((r_cr_count != '0) || w_full);

    // Number of CR bytes currently held in the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cr_count <= '0;
        end else begin
            case ({w_push_cr, w_pop_cr})
                2'b10:   r_cr_count <= r_cr_count + c_CNT_ONE;
                2'b01:   r_cr_count <= r_cr_count - c_CNT_ONE;
                default: r_cr_count <= r_cr_count;
            endcase
        end
    end
`else
    assign tx_valid = !w_empty;
`endif

    // Storage is not reset; stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (rx_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_buffer
// Brief    : Self-checking bench for uart_echo_buffer. A queue-based model
//            tracks buffered bytes; each scenario task checks the DUT inline.
// Options  : UART_ECHO_LINE_MODE_EN - enables the line-mode scenario and
//            line-mode expectations in the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_buffer;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [4:0]       count;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: bytes held in order, and the sticky flag.
    logic [7:0] q[$];
    bit         m_ovf;

    always #5 clk = ~clk;

    uart_echo_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .count    (count),
        .overflow (overflow)
    );

    function automatic logic [7:0] swap_case(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    function automatic bit m_tx_valid();
`ifdef UART_ECHO_LINE_MODE_EN
        bit has_cr;
        has_cr = 1'b0;
        foreach (q[i]) if (q[i] == 8'h0D) has_cr = 1'b1;
        return (q.size() != 0) && (has_cr || q.size() == DEPTH);
`else
        return q.size() != 0;
`endif
    endfunction

    // Drive one cycle of stimulus and advance the model; leaves time at posedge+1.
    task automatic step(input bit rv, input logic [7:0] rd, input bit tr);
        bit push, pop;
        rx_valid = rv;
        rx_data  = rd;
        tx_ready = tr;
        push = rv && (q.size() != DEPTH);
        pop  = m_tx_valid() && tr;
        if (rv && q.size() == DEPTH) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(swap_case(rd));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_first_byte();
        do_reset();
        step(1'b1, 8'h41, 1'b1);
        n_tests++; if (tx_valid !== m_tx_valid()) begin n_fail++; $display("FAIL first_tx_valid: got %b want %b", tx_valid, m_tx_valid()); end
        n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL first_count: got %0d want 1", count); end
        n_tests++; if (tx_data !== 8'h61) begin n_fail++; $display("FAIL first_tx_data: got %h want 61", tx_data); end
        step(1'b0, 8'h00, 1'b1);
        n_tests++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL first_count_after_pop: got %0d want %0d", count, q.size()); end
    endtask

    task automatic test_transform();
        logic [7:0] ins [6] = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h7A, 8'h31};
        logic [7:0] exp [6] = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h5A, 8'h31};
        logic [7:0] got[$];
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, ins[i], 1'b0);
`ifdef UART_ECHO_LINE_MODE_EN
        step(1'b1, 8'h0D, 1'b0);
`endif
        for (int k = 0; k < 20; k++) begin
            if (tx_valid) got.push_back(tx_data);
            step(1'b0, 8'h00, 1'b1);
        end
        n_tests++; if (got.size() < 6) begin n_fail++; $display("FAIL xform_len: got %0d want >=6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_tests++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL xform_byte%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_full_overflow();
        logic [7:0] got[$];
        int exp_len;
        do_reset();
        // Move the pointers away from zero so the fill wraps.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h0D, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        n_tests++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL full_pre_count: got %0d want %0d", count, q.size()); end
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", count); end
        n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL full_rx_ready: got %b want 0", rx_ready); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_early: got %b want 0", overflow); end
        step(1'b1, 8'hAA, 1'b0);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf_set: got %b want 1", overflow); end
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count_hold: got %0d want 16", count); end
        for (int k = 0; k < 40; k++) begin
            if (tx_valid) got.push_back(tx_data);
            step(1'b0, 8'h00, 1'b1);
        end
`ifdef UART_ECHO_LINE_MODE_EN
        exp_len = 14;
`else
        exp_len = 16;
`endif
        n_tests++; if (got.size() != exp_len) begin n_fail++; $display("FAIL drain_len: got %0d want %0d", got.size(), exp_len); end
        foreach (got[i]) begin
            n_tests++; if (got[i] !== 8'(i)) begin n_fail++; $display("FAIL drain_byte%0d: got %h want %h", i, got[i], 8'(i)); end
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drain_ovf_sticky: got %b want 1", overflow); end
        n_tests++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", count, q.size()); end
        do_reset();
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 8'($urandom), 1'b1);
`ifndef UART_ECHO_LINE_MODE_EN
            n_tests++; if (count !== 5'd8) begin n_fail++; $display("FAIL stream_count%0d: got %0d want 8", k, count); end
`endif
            n_tests++; if (tx_valid !== m_tx_valid()) begin n_fail++; $display("FAIL stream_valid%0d: got %b want %b", k, tx_valid, m_tx_valid()); end
            if (q.size() != 0) begin
                n_tests++; if (tx_data !== q[0]) begin n_fail++; $display("FAIL stream_data%0d: got %h want %h", k, tx_data, q[0]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        do_reset();
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", tx_valid); end
        n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b1);
            n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_after%0d: got %b want 0", k, tx_valid); end
        end
    endtask

    task automatic test_random();
        bit         rv, tr;
        logic [7:0] d;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rv = ($urandom_range(0, 3) != 0);
            tr = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
            step(rv, d, tr);
            n_tests++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL rnd_count%0d: got %0d want %0d", k, count, q.size()); end
            n_tests++; if (rx_ready !== (q.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_rx_ready%0d: got %b want %b", k, rx_ready, q.size() != DEPTH); end
            n_tests++; if (tx_valid !== m_tx_valid()) begin n_fail++; $display("FAIL rnd_valid%0d: got %b want %b", k, tx_valid, m_tx_valid()); end
            n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf%0d: got %b want %b", k, overflow, m_ovf); end
            if (q.size() != 0) begin
                n_tests++; if (tx_data !== q[0]) begin n_fail++; $display("FAIL rnd_data%0d: got %h want %h", k, tx_data, q[0]); end
            end
        end
    endtask

`ifdef UART_ECHO_LINE_MODE_EN
    task automatic test_line_mode();
        logic [7:0] got[$];
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h0D};
        do_reset();
        step(1'b1, 8'h61, 1'b1);
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL line_hold_a: got %b want 0", tx_valid); end
        step(1'b1, 8'h62, 1'b1);
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL line_hold_b: got %b want 0", tx_valid); end
        step(1'b1, 8'h0D, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (tx_valid) got.push_back(tx_data);
            step(1'b0, 8'h00, 1'b1);
        end
        n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL line_len: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_tests++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL line_byte%0d: got %h want %h", i, got[i], exp[i]); end
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'h30 + 8'(i), 1'b1);
            n_tests++; if (tx_valid !== (i == 15)) begin n_fail++; $display("FAIL line_full%0d: got %b want %b", i, tx_valid, i == 15); end
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b0;
        m_ovf    = 1'b0;
        test_reset();
        test_first_byte();
        test_transform();
        test_full_overflow();
        test_stream();
        test_reset_mid();
        test_random();
`ifdef UART_ECHO_LINE_MODE_EN
        test_line_mode();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
